bsg_downstream_param: RTL

BSG_DOWNSTREAM_PARAM -- requirements
Module: bsg_downstream_param

---
 rtl/bsg_downstream_param.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/bsg_downstream_param.sv
// bsg_downstream_param
// Receive side of a credit-based off-chip link. Beats of IO_W bits are
// deserialized into entries of WORD_BEATS beats and written into a
// 2^DEPTH_LG-entry buffer. An output FSM pops CORE_ENTRIES entries into a
// core word and presents it with a valid/ready handshake. Every
// 2^TOKEN_LG popped entries flips io_token_o, returning credit upstream.
//
// Ports
//   clk           clock, all state changes on its rising edge
//   rst           synchronous active-high reset
//   io_valid_i    a beat is present this cycle
//   io_data_i     beat data (IO_W bits)
//   io_token_o    credit toggle returned upstream
//   core_data_o   assembled core word (IO_W*WORD_BEATS*CORE_ENTRIES bits)
//   core_valid_o  core word valid
//   core_ready_i  core accepts the word
//   full_o        buffer full
//   overflow_o    sticky: a completed entry was dropped
module bsg_downstream_param #(
  parameter int IO_W         = 1,
  parameter int WORD_BEATS   = 2,
  parameter int CORE_ENTRIES = 2,
  parameter int DEPTH_LG     = 3,
  parameter int TOKEN_LG     = 2
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      io_valid_i,
  input  logic [IO_W-1:0]                           io_data_i,
  output logic                                      io_token_o,
  output logic [IO_W*WORD_BEATS*CORE_ENTRIES-1:0]   core_data_o,
  output logic                                      core_valid_o,
  input  logic                                      core_ready_i,
  output logic                                      full_o,
  output logic                                      overflow_o
);

  localparam int E      = IO_W * WORD_BEATS;
  localparam int CORE_W = E * CORE_ENTRIES;
  localparam int DEPTH  = 1 << DEPTH_LG;
  localparam int BEAT_W = (WORD_BEATS > 1) ? $clog2(WORD_BEATS) : 1;
  localparam int PH_W   = (CORE_ENTRIES > 1) ? $clog2(CORE_ENTRIES) : 1;
  localparam int PTR_W  = DEPTH_LG + 1;

  typedef enum logic {GATHER, PRESENT} state_t;

  logic [BEAT_W-1:0] r_beat;
  logic [E-1:0]      r_entry;
  logic [E-1:0]      w_entry;
  logic              w_last;
  logic              w_wr;
  logic [E-1:0]      r_buf [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [PTR_W-1:0]  w_rptr_inc;
  logic              w_empty;
  logic              w_full;
  logic              w_pop;
  logic              r_ovf;
  logic              r_token;
  logic [PH_W-1:0]   r_phase;
  logic [CORE_W-1:0] r_core;
  state_t            r_state;
  state_t            w_state_next;

  // Entry as it will look once the current beat is merged in; on the last
  // beat this is the value committed to the buffer.
  always_comb begin
    w_entry = r_entry;
    w_entry[int'(r_beat)*IO_W +: IO_W] = io_data_i;
  end

  assign w_last     = io_valid_i && (r_beat == BEAT_W'(WORD_BEATS - 1));
  // A pop on the same edge frees the slot being written, so a full buffer
  // still accepts the entry in that case.
  assign w_wr       = w_last && (!w_full || w_pop);
  assign w_empty    = (r_wptr == r_rptr);
  assign w_full     = (r_wptr[DEPTH_LG] != r_rptr[DEPTH_LG]) &&
                      (r_wptr[DEPTH_LG-1:0] == r_rptr[DEPTH_LG-1:0]);
  assign w_rptr_inc = r_rptr + PTR_W'(1);

  // ---- input stage: deserializer and buffer write ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat <= '0;
      r_wptr <= '0;
      r_ovf  <= 1'b0;
    end else if (io_valid_i) begin
      if (w_last) begin
        r_beat <= '0;
        if (w_wr) r_wptr <= r_wptr + PTR_W'(1);
        else      r_ovf  <= 1'b1;
      end else begin
        r_beat <= r_beat + BEAT_W'(1);
      end
    end
  end

  // Partial entry data needs no reset: the beat counter restarts at 0 and
  // every beat of the next entry overwrites its slice.
  always_ff @(posedge clk) begin
    if (!rst && io_valid_i) r_entry <= w_entry;
  end

  always_ff @(posedge clk) begin
    if (!rst && w_wr) r_buf[r_wptr[DEPTH_LG-1:0]] <= w_entry;
  end

  // ---- output stage: gather entries into a core word ----
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    case (r_state)
      GATHER: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          if (r_phase == PH_W'(CORE_ENTRIES - 1)) w_state_next = PRESENT;
        end
      end
      PRESENT: begin
        if (core_ready_i) w_state_next = GATHER;
      end
      default: w_state_next = GATHER;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= GATHER;
      r_phase <= '0;
      r_rptr  <= '0;
      r_token <= 1'b0;
      r_core  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_pop) begin
        r_core[int'(r_phase)*E +: E] <= r_buf[r_rptr[DEPTH_LG-1:0]];
        r_rptr  <= w_rptr_inc;
        r_token <= w_rptr_inc[TOKEN_LG];
        if (r_phase == PH_W'(CORE_ENTRIES - 1)) r_phase <= '0;
        else                                    r_phase <= r_phase + PH_W'(1);
      end
    end
  end

  assign core_data_o  = r_core;
  assign core_valid_o = (r_state == PRESENT);
  assign io_token_o   = r_token;
  assign full_o       = w_full;
  assign overflow_o   = r_ovf;

endmodule
